bist_response_analyzer: RTL and testbench
=========================================

Name: bist_response_analyzer

Overview:
- Read-side counterpart to the BIST pattern writer: observes RAM read data during a March-style test, compares it against the expected pattern, and accumulates pass/fail status.
- Aligns each issued read's address and expected data with RAM read latency, counts mismatches (saturating), captures the first failing address and data, and reports a final verdict.
- Sits between the BIST controller (issues reads) and the RAM data output.

Parameters:
- ADDR_W, 3: RAM address width.
- DATA_W, 8: RAM data width.
- RD_LAT, 1: RAM read latency in cycles; legal range 1..4.
- FAIL_CNT_W, 4: mismatch counter width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- async_reset  in  1  asynchronous, active-high reset.
- start  in  1  clears all results and arms the analyzer (ACTIVE).
- rd_en  in  1  controller issued a RAM read this cycle.
- rd_addr  in  ADDR_W  address of the issued read.
- exp_data  in  DATA_W  expected data for the issued read.
- ram_dout  in  DATA_W  RAM read data, valid RD_LAT cycles after rd_en.
- test_end  in  1  controller finished issuing reads; a read in the same cycle counts.
- done  out  1  verdict valid; held until start or reset.
- pass  out  1  done and zero mismatches.
- fail  out  1  at least one mismatch seen; updates live.
- fail_count  out  FAIL_CNT_W  saturating mismatch count.
- first_fail_addr  out  ADDR_W  address of the first mismatch.
- first_fail_data  out  DATA_W  ram_dout at the first mismatch.
- fail_bits  out  DATA_W  OR-accumulated syndrome (see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - state IDLE, delay line cleared.
  - All outputs 0.
- States: IDLE, ACTIVE, DRAIN, DONE.
  - IDLE: rd_en ignored.
  - start in any state: clear results and delay line; go to ACTIVE next cycle.
  - ACTIVE: rd_en pushes {valid, rd_addr, exp_data} into an RD_LAT-deep delay line.
  - ACTIVE + test_end: go to DRAIN; that cycle's rd_en is still pushed.
  - DRAIN: rd_en ignored (nothing pushed); exit to DONE when the delay line holds no valid entry.
  - DONE: done=1, pass=(fail_count==0); outputs held.
- Compare stage:
  - A delay-line output with valid set compares ram_dout against the delayed exp_data in that cycle.
  - Results are registered; they are visible the cycle after compare.
  - For a read issued at cycle t, results are visible at t+RD_LAT+1.
- Mismatch handling:
  - fail_count increments and saturates at 2^FAIL_CNT_W-1, with no wrap.
  - fail goes to 1.
  - first_fail_addr/first_fail_data are loaded only when fail_count was 0 before this mismatch.
- Timing: with test_end at cycle T, done and pass become visible at T+RD_LAT+1.
- Simultaneous start and test_end: start wins.
- start during DRAIN: in-flight reads are discarded, not compared.
- Reset mid-test: results are lost; after reset, reads are ignored until start.

Optional Feature:
- Macro: BIST_SYNDROME_EN.
- Defined: fail_bits |= (ram_dout ^ exp_delayed) on every valid compare; cleared by start and reset.
- Undefined: fail_bits is tied to 0 and the accumulator logic is absent.
- All other behaviour is identical either way.

Decomposition:
- Package bist_pkg:
  - analyzer state enum (IDLE/ACTIVE/DRAIN/DONE).
  - default width constants ADDR_W/DATA_W/FAIL_CNT_W.
  - RD_LAT maximum constant.
- Sub-module bist_delay_line: RD_LAT-stage register pipeline of {valid, addr, exp}.
  - Built from async-reset flops.
  - Synchronous flush input driven by start.
  - Exposes an any_valid flag used for DRAIN exit.

Test Plan:
- Reset: assert async_reset mid-cycle -> all outputs 0 immediately, no clock edge required.
- Clean run:
  - Stimulus: RD_LAT=1; start, then 8 reads addr 0..7, exp 0x55, dout 0x55; test_end with the last read.
  - Response: done=1 and pass=1 two cycles after test_end; fail_count=0; fail=0.
- Two faults:
  - Stimulus: addr 3 dout 0x57, addr 6 dout 0x00, others match.
  - Response: fail_count=2, first_fail_addr=3, first_fail_data=0x57, pass=0, done=1, fail=1; fail_bits=0x57 with the macro, 0x00 without.
- Saturation: 20 consecutive mismatches -> fail_count=15 (stays 15), first_fail_addr = first mismatching address.
- Reset mid-test: reset after read 4 -> outputs 0; further rd_en/test_end without start -> done stays 0, fail_count stays 0.
- Restart: start and test_end in the same cycle while in DONE -> ACTIVE, all results cleared, done=0 next cycle; RD_LAT=3 rerun gives done at T+4.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST response analyzer slice.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int DEF_ADDR_W     = 3;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FAIL_CNT_W = 4;
  localparam int RD_LAT_MAX     = 4;

  // Out-of-range latencies are pulled back into the supported window.
  function automatic int clamp_lat(input int lat);
    if (lat < 1)
      return 1;
    else if (lat > RD_LAT_MAX)
      return RD_LAT_MAX;
    else
      return lat;
  endfunction

endpackage

// File: rtl/bist_response_analyzer_if.sv
// Controller/RAM-side bundle of the response analyzer; master = controller + RAM, slave = analyzer.
interface bist_response_analyzer_if
  import bist_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FAIL_CNT_W = DEF_FAIL_CNT_W
) ();

  logic                  start;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     exp_data;
  logic [DATA_W-1:0]     ram_dout;
  logic                  test_end;
  logic                  done;
  logic                  pass;
  logic                  fail;
  logic [FAIL_CNT_W-1:0] fail_count;
  logic [ADDR_W-1:0]     first_fail_addr;
  logic [DATA_W-1:0]     first_fail_data;
  logic [DATA_W-1:0]     fail_bits;

  modport master (
    output start, rd_en, rd_addr, exp_data, ram_dout, test_end,
    input  done, pass, fail, fail_count, first_fail_addr, first_fail_data, fail_bits
  );

  modport slave (
    input  start, rd_en, rd_addr, exp_data, ram_dout, test_end,
    output done, pass, fail, fail_count, first_fail_addr, first_fail_data, fail_bits
  );

endinterface

// File: rtl/bist_delay_line.sv
// Pipeline of {valid, addr, exp} that lines issued reads up with RAM read latency.
module bist_delay_line
  import bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              async_reset,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_exp,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_exp,
  output logic              o_any_valid
);

  localparam int DEPTH = clamp_lat(RD_LAT);

  logic [DEPTH-1:0] w_valid;
  logic [ADDR_W-1:0] w_addr [DEPTH];
  logic [DATA_W-1:0] w_exp  [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic              w_in_valid;
      logic [ADDR_W-1:0] w_in_addr;
      logic [DATA_W-1:0] w_in_exp;
      logic              r_valid;
      logic [ADDR_W-1:0] r_addr;
      logic [DATA_W-1:0] r_exp;

      if (gi == 0) begin : g_head
        assign w_in_valid = i_push;
        assign w_in_addr  = i_addr;
        assign w_in_exp   = i_exp;
      end else begin : g_body
        assign w_in_valid = w_valid[gi-1];
        assign w_in_addr  = w_addr[gi-1];
        assign w_in_exp   = w_exp[gi-1];
      end

      always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
          r_valid <= 1'b0;
          r_addr  <= '0;
          r_exp   <= '0;
        end else if (i_flush) begin
          r_valid <= 1'b0;
          r_addr  <= '0;
          r_exp   <= '0;
        end else begin
          r_valid <= w_in_valid;
          r_addr  <= w_in_addr;
          r_exp   <= w_in_exp;
        end
      end

      assign w_valid[gi] = r_valid;
      assign w_addr[gi]  = r_addr;
      assign w_exp[gi]   = r_exp;
    end

    // Only entries behind the output stage count: the output stage is compared this cycle.
    if (DEPTH > 1) begin : g_pend
      assign o_any_valid = |w_valid[DEPTH-2:0];
    end else begin : g_nopend
      assign o_any_valid = 1'b0;
    end
  endgenerate

  assign o_valid = w_valid[DEPTH-1];
  assign o_addr  = w_addr[DEPTH-1];
  assign o_exp   = w_exp[DEPTH-1];

endmodule

// File: rtl/bist_response_analyzer.sv
// Compares RAM read data against delayed expected data and accumulates the verdict.
// Define BIST_SYNDROME_EN to build the OR-accumulated fail_bits syndrome.
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int FAIL_CNT_W = DEF_FAIL_CNT_W
) (
  input logic                     clk,
  input logic                     async_reset,
  bist_response_analyzer_if.slave bus
);

  localparam logic [FAIL_CNT_W-1:0] CNT_MAX = '1;

  state_t                r_state;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_fail;
  logic [FAIL_CNT_W-1:0] r_fail_count;
  logic [ADDR_W-1:0]     r_first_fail_addr;
  logic [DATA_W-1:0]     r_first_fail_data;

  logic                  w_push;
  logic                  w_dl_valid;
  logic [ADDR_W-1:0]     w_dl_addr;
  logic [DATA_W-1:0]     w_dl_exp;
  logic                  w_any_valid;
  logic                  w_cmp;
  logic                  w_mismatch;
  logic [FAIL_CNT_W-1:0] w_cnt_next;

  assign w_push = (r_state == ST_ACTIVE) && bus.rd_en && !bus.start;

  bist_delay_line #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_delay_line (
    .clk         (clk),
    .async_reset (async_reset),
    .i_flush     (bus.start),
    .i_push      (w_push),
    .i_addr      (bus.rd_addr),
    .i_exp       (bus.exp_data),
    .o_valid     (w_dl_valid),
    .o_addr      (w_dl_addr),
    .o_exp       (w_dl_exp),
    .o_any_valid (w_any_valid)
  );

  // A start in the same cycle discards whatever is arriving from the RAM.
  assign w_cmp      = w_dl_valid && !bus.start;
  assign w_mismatch = w_cmp && (bus.ram_dout != w_dl_exp);
  assign w_cnt_next = (w_mismatch && (r_fail_count != CNT_MAX)) ?
                      r_fail_count + FAIL_CNT_W'(1) : r_fail_count;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_state           <= ST_IDLE;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_fail            <= 1'b0;
      r_fail_count      <= '0;
      r_first_fail_addr <= '0;
      r_first_fail_data <= '0;
    end else if (bus.start) begin
      r_state           <= ST_ACTIVE;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_fail            <= 1'b0;
      r_fail_count      <= '0;
      r_first_fail_addr <= '0;
      r_first_fail_data <= '0;
    end else begin
      if (w_mismatch) begin
        r_fail       <= 1'b1;
        r_fail_count <= w_cnt_next;
        if (r_fail_count == '0) begin
          r_first_fail_addr <= w_dl_addr;
          r_first_fail_data <= bus.ram_dout;
        end
      end
      case (r_state)
        ST_ACTIVE: begin
          if (bus.test_end)
            r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // The last in-flight read is compared this cycle, so the verdict includes it.
          if (!w_any_valid) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_pass  <= (w_cnt_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BIST_SYNDROME_EN
  logic [DATA_W-1:0] r_fail_bits;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset)
      r_fail_bits <= '0;
    else if (bus.start)
      r_fail_bits <= '0;
    else if (w_cmp)
      r_fail_bits <= r_fail_bits | (bus.ram_dout ^ w_dl_exp);
  end

  assign bus.fail_bits = r_fail_bits;
`else
  assign bus.fail_bits = '0;
`endif

  assign bus.done            = r_done;
  assign bus.pass            = r_pass;
  assign bus.fail            = r_fail;
  assign bus.fail_count      = r_fail_count;
  assign bus.first_fail_addr = r_first_fail_addr;
  assign bus.first_fail_data = r_first_fail_data;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed bench: one analyzer at read latency 1 and one at latency 3 share the same stimulus.
module tb_bist_response_analyzer;
  import bist_pkg::*;

`ifdef BIST_SYNDROME_EN
  localparam bit SYN_ON = 1'b1;
`else
  localparam bit SYN_ON = 1'b0;
`endif

  logic clk;
  logic async_reset;
  int   n_total;
  int   n_pass;
  logic [7:0] pipe1;
  logic [7:0] pipe3 [3];

  bist_response_analyzer_if #(.ADDR_W(3), .DATA_W(8), .FAIL_CNT_W(4)) bus1 ();
  bist_response_analyzer_if #(.ADDR_W(3), .DATA_W(8), .FAIL_CNT_W(4)) bus3 ();

  bist_response_analyzer #(.ADDR_W(3), .DATA_W(8), .RD_LAT(1), .FAIL_CNT_W(4)) dut1 (
    .clk         (clk),
    .async_reset (async_reset),
    .bus         (bus1)
  );

  bist_response_analyzer #(.ADDR_W(3), .DATA_W(8), .RD_LAT(3), .FAIL_CNT_W(4)) dut3 (
    .clk         (clk),
    .async_reset (async_reset),
    .bus         (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  // One clock of stimulus; the RAM model returns dout_v RD_LAT cycles later on each bus.
  task automatic step(input logic en, input logic [2:0] addr, input logic [7:0] exp_v,
                      input logic [7:0] dout_v, input logic te, input logic st);
    bus1.ram_dout = pipe1;
    pipe1         = dout_v;
    bus3.ram_dout = pipe3[2];
    pipe3[2]      = pipe3[1];
    pipe3[1]      = pipe3[0];
    pipe3[0]      = dout_v;
    bus1.start = st;  bus1.rd_en = en;  bus1.rd_addr = addr;  bus1.exp_data = exp_v;  bus1.test_end = te;
    bus3.start = st;  bus3.rd_en = en;  bus3.rd_addr = addr;  bus3.exp_data = exp_v;  bus3.test_end = te;
    @(posedge clk);
    #1;
    $display("step st=%0b en=%0b addr=%0d exp=%02h dout=%02h te=%0b | L1 done=%0b pass=%0b cnt=%0d | L3 done=%0b cnt=%0d",
             st, en, addr, exp_v, dout_v, te, bus1.done, bus1.pass, bus1.fail_count, bus3.done, bus3.fail_count);
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    pipe1   = 8'h00;
    for (int i = 0; i < 3; i++) pipe3[i] = 8'h00;
    async_reset = 1'b1;
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset state
    chk("rst_done", 32'(bus1.done), 32'd0);
    chk("rst_pass", 32'(bus1.pass), 32'd0);
    chk("rst_fail", 32'(bus1.fail), 32'd0);
    chk("rst_cnt", 32'(bus1.fail_count), 32'd0);
    chk("rst_ffa", 32'(bus1.first_fail_addr), 32'd0);
    chk("rst_ffd", 32'(bus1.first_fail_data), 32'd0);
    chk("rst_fbits", 32'(bus1.fail_bits), 32'd0);
    async_reset = 1'b0;

    // Clean run
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("clean_done_after_start", 32'(bus1.done), 32'd0);
    for (int i = 0; i < 8; i++)
      step(1'b1, 3'(i), 8'h55, 8'h55, (i == 7), 1'b0);
    chk("clean_done_T1", 32'(bus1.done), 32'd0);
    idle();
    chk("clean_done_T2", 32'(bus1.done), 32'd1);
    chk("clean_pass", 32'(bus1.pass), 32'd1);
    chk("clean_cnt", 32'(bus1.fail_count), 32'd0);
    chk("clean_fail", 32'(bus1.fail), 32'd0);
    chk("clean_L3_done_T2", 32'(bus3.done), 32'd0);
    idle();
    chk("clean_L3_done_T3", 32'(bus3.done), 32'd0);
    idle();
    chk("clean_L3_done_T4", 32'(bus3.done), 32'd1);
    chk("clean_L3_pass", 32'(bus3.pass), 32'd1);
    chk("clean_done_held", 32'(bus1.done), 32'd1);

    // Two faults
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("fault_cleared_done", 32'(bus1.done), 32'd0);
    for (int i = 0; i < 8; i++)
      step(1'b1, 3'(i), 8'h55, (i == 3) ? 8'h57 : ((i == 6) ? 8'h00 : 8'h55), (i == 7), 1'b0);
    chk("fault_fail_live", 32'(bus1.fail), 32'd1);
    chk("fault_done_T1", 32'(bus1.done), 32'd0);
    idle();
    chk("fault_cnt", 32'(bus1.fail_count), 32'd2);
    chk("fault_ffa", 32'(bus1.first_fail_addr), 32'd3);
    chk("fault_ffd", 32'(bus1.first_fail_data), 32'h57);
    chk("fault_pass", 32'(bus1.pass), 32'd0);
    chk("fault_done", 32'(bus1.done), 32'd1);
    chk("fault_fail", 32'(bus1.fail), 32'd1);
    chk("fault_fbits", 32'(bus1.fail_bits), SYN_ON ? 32'h57 : 32'h00);
    idle();
    idle();
    chk("fault_L3_cnt", 32'(bus3.fail_count), 32'd2);
    chk("fault_L3_ffa", 32'(bus3.first_fail_addr), 32'd3);

    // Saturation: two good reads, then 20 mismatches starting at address 2
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 22; i++)
      step(1'b1, 3'(i % 8), 8'hAA, (i < 2) ? 8'hAA : 8'hA0, (i == 21), 1'b0);
    idle();
    idle();
    idle();
    chk("sat_cnt", 32'(bus1.fail_count), 32'd15);
    chk("sat_ffa", 32'(bus1.first_fail_addr), 32'd2);
    chk("sat_ffd", 32'(bus1.first_fail_data), 32'hA0);
    chk("sat_done", 32'(bus1.done), 32'd1);
    chk("sat_pass", 32'(bus1.pass), 32'd0);
    chk("sat_fbits", 32'(bus1.fail_bits), SYN_ON ? 32'h0A : 32'h00);
    chk("sat_L3_cnt", 32'(bus3.fail_count), 32'd15);
    chk("sat_L3_done", 32'(bus3.done), 32'd1);

    // Reset mid-test after read 4 (read 1 mismatches so there is something to lose)
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      step(1'b1, 3'(i), 8'h33, (i == 1) ? 8'h30 : 8'h33, 1'b0, 1'b0);
    chk("midrst_pre_fail", 32'(bus1.fail), 32'd1);
    #2;
    async_reset = 1'b1;
    #1;
    chk("midrst_fail", 32'(bus1.fail), 32'd0);
    chk("midrst_cnt", 32'(bus1.fail_count), 32'd0);
    chk("midrst_ffa", 32'(bus1.first_fail_addr), 32'd0);
    chk("midrst_ffd", 32'(bus1.first_fail_data), 32'd0);
    @(posedge clk);
    #1;
    async_reset = 1'b0;
    for (int i = 0; i < 4; i++)
      step(1'b1, 3'(i), 8'h33, 8'hCC, (i == 3), 1'b0);
    idle();
    idle();
    idle();
    idle();
    chk("midrst_after_done", 32'(bus1.done), 32'd0);
    chk("midrst_after_cnt", 32'(bus1.fail_count), 32'd0);
    chk("midrst_after_fail", 32'(bus1.fail), 32'd0);
    chk("midrst_after_L3_done", 32'(bus3.done), 32'd0);

    // Restart from DONE with start and test_end together, then a latency-3 rerun
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b1, 3'd0, 8'h77, 8'h77, 1'b0, 1'b0);
    step(1'b1, 3'd1, 8'h77, 8'h70, 1'b1, 1'b0);
    idle();
    idle();
    idle();
    chk("restart_pre_done", 32'(bus3.done), 32'd1);
    chk("restart_pre_fail", 32'(bus1.fail), 32'd1);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("restart_done", 32'(bus1.done), 32'd0);
    chk("restart_L3_done", 32'(bus3.done), 32'd0);
    chk("restart_cnt", 32'(bus1.fail_count), 32'd0);
    chk("restart_fail", 32'(bus1.fail), 32'd0);
    chk("restart_ffa", 32'(bus1.first_fail_addr), 32'd0);
    chk("restart_fbits", 32'(bus1.fail_bits), 32'd0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 3'(i + 4), 8'h0F, 8'h0F, (i == 2), 1'b0);
    chk("rerun_L3_T1", 32'(bus3.done), 32'd0);
    idle();
    chk("rerun_L3_T2", 32'(bus3.done), 32'd0);
    chk("rerun_L1_T2", 32'(bus1.done), 32'd1);
    idle();
    chk("rerun_L3_T3", 32'(bus3.done), 32'd0);
    idle();
    chk("rerun_L3_T4", 32'(bus3.done), 32'd1);
    chk("rerun_L3_pass", 32'(bus3.pass), 32'd1);

    // Start during DRAIN discards the in-flight mismatching read
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b1, 3'd5, 8'h11, 8'h22, 1'b1, 1'b0);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    idle();
    idle();
    idle();
    idle();
    chk("drain_start_cnt", 32'(bus1.fail_count), 32'd0);
    chk("drain_start_fail", 32'(bus1.fail), 32'd0);
    chk("drain_start_done", 32'(bus1.done), 32'd0);
    chk("drain_start_L3_cnt", 32'(bus3.fail_count), 32'd0);
    chk("drain_start_L3_fail", 32'(bus3.fail), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
